// File: rtl/mode_ramp_if.sv
// mode_ramp_if: pilot command inputs and mode/setpoint outputs of the flight-mode ramp FSM.
interface mode_ramp_if #(parameter int RPM_W = 14);
  logic ARM;
  logic LEVER;
  logic [2:0] DIRECTION;
  logic [4*RPM_W-1:0] SETPOINT;
  logic [4*RPM_W-1:0] PRV_SETPOINT;
  logic [3:0] MODE;
  logic [3:0] PRV_MODE;
  logic RAMP_BUSY;
  logic MODE_CHG;
  modport master (
    output ARM, LEVER, DIRECTION,
    input  SETPOINT, PRV_SETPOINT, MODE, PRV_MODE, RAMP_BUSY, MODE_CHG
  );
  modport slave (
    input  ARM, LEVER, DIRECTION,
    output SETPOINT, PRV_SETPOINT, MODE, PRV_MODE, RAMP_BUSY, MODE_CHG
  );
endinterface

// File: rtl/mode_ramp_fsm.sv
// mode_ramp_fsm: debounced flight-mode FSM driving slew-limited per-fan RPM setpoints.
module mode_ramp_fsm #(
  parameter int RPM_W      = 14,
  parameter int HOVER_RPM  = 8000,
  parameter int DELTA_RPM  = 2000,
  parameter int STEP_RPM   = 250,
  parameter int TICK_DIV   = 1000,
  parameter int DEB_CYCLES = 4
) (
  input logic CLK,
  input logic nRST,
  mode_ramp_if.slave bus
);
  typedef enum logic [3:0] {
    HOVER, FORWARD, BACKWARD, RIGHT, LEFT, CW, CCW, UP, DOWN, DISARM
  } mode_t;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [RPM_W-1:0] RPM_M = RPM_W'(HOVER_RPM);
  localparam logic [RPM_W-1:0] RPM_H = RPM_W'(HOVER_RPM + DELTA_RPM);
  localparam logic [RPM_W-1:0] RPM_L = RPM_W'(HOVER_RPM - DELTA_RPM);
  localparam logic [RPM_W-1:0] STEP  = RPM_W'(STEP_RPM);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
  mode_t mode, mode_nxt, prv_mode;
  logic [3:0] cmd, cmd_q;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] tick_cnt;
  logic [4*RPM_W-1:0] tgt;
  logic cmd_ok, tick, busy, mode_chg;
  // bit k of hi/lo selects the high/low target for fan k+1
  function automatic logic [4*RPM_W-1:0] targets(mode_t m);
    logic [3:0] hi, lo;
    logic [4*RPM_W-1:0] r;
    {hi, lo} = 8'b0000_0000;
    case (m)
      FORWARD:  {hi, lo} = 8'b0110_1001;
      BACKWARD: {hi, lo} = 8'b1001_0110;
      RIGHT:    {hi, lo} = 8'b1100_0011;
      LEFT:     {hi, lo} = 8'b0011_1100;
      CW:       {hi, lo} = 8'b0101_1010;
      CCW:      {hi, lo} = 8'b1010_0101;
      UP:       {hi, lo} = 8'b1111_0000;
      DOWN:     {hi, lo} = 8'b0000_1111;
      default:  {hi, lo} = 8'b0000_0000;
    endcase
    for (int k = 0; k < 4; k++)
      r[k*RPM_W +: RPM_W] = m == DISARM ? '0 : hi[k] ? RPM_H : lo[k] ? RPM_L : RPM_M;
    return r;
  endfunction
  function automatic mode_t decode(logic [3:0] c);
    case (c)
      4'b1001: return FORWARD;
      4'b1010: return BACKWARD;
      4'b1011: return RIGHT;
      4'b1100: return LEFT;
      4'b0001: return UP;
      4'b0010: return DOWN;
      4'b0011: return CCW;
      4'b0100: return CW;
      default: return HOVER;
    endcase
  endfunction
  assign cmd    = {bus.LEVER, bus.DIRECTION};
  assign cmd_ok = deb_cnt == DEB_MAX;
  assign tick   = tick_cnt == TICK_LAST;
  assign tgt    = targets(mode);
  assign busy   = bus.SETPOINT != tgt;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      cmd_q    <= '0;
      deb_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      cmd_q    <= cmd;
      deb_cnt  <= cmd != cmd_q ? '0 : cmd_ok ? deb_cnt : deb_cnt + 1'b1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  // disarm wins outright; every other move waits for a settled command and an idle ramp
  always_comb begin
    mode_nxt = mode;
    if (!bus.ARM)
      mode_nxt = DISARM;
    else if (cmd_ok && !busy)
      mode_nxt = mode == HOVER ? decode(cmd_q) : cmd_q[2:0] == 3'd0 ? HOVER : mode;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      mode     <= HOVER;
      prv_mode <= HOVER;
      mode_chg <= 1'b0;
    end else begin
      mode     <= mode_nxt;
      mode_chg <= mode_nxt != mode;
      if (mode_nxt != mode) prv_mode <= mode;
    end
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [RPM_W-1:0] sp, t, diff, step;
    assign t    = tgt[g*RPM_W +: RPM_W];
    assign diff = t > sp ? t - sp : sp - t;
    assign step = diff < STEP ? diff : STEP;
    always_ff @(posedge CLK or negedge nRST)
      if (!nRST) sp <= RPM_M;
      else if (tick) sp <= t > sp ? sp + step : sp - step;
    assign bus.SETPOINT[g*RPM_W +: RPM_W] = sp;
  end
  assign bus.PRV_SETPOINT = targets(prv_mode);
  assign bus.MODE         = mode;
  assign bus.PRV_MODE     = prv_mode;
  assign bus.RAMP_BUSY    = busy;
  assign bus.MODE_CHG     = mode_chg;
  a_mode_legal: assert property (@(posedge CLK) disable iff (!nRST) mode <= DISARM);
endmodule

// File: tb/tb_mode_ramp_fsm.sv
// tb_mode_ramp_fsm: vector table plus per-lane ramp scoreboard for mode_ramp_fsm.
module tb_mode_ramp_fsm;
  localparam int W = 14;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  mode_ramp_if #(.RPM_W(W)) bus ();
  mode_ramp_fsm #(.RPM_W(W), .TICK_DIV(4), .DEB_CYCLES(3)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  typedef struct {
    bit lev;
    logic [2:0] dir;
    int exp;
  } vec_t;
  vec_t tbl [8];
  string pat [10];
  int errs = 0, checks = 0;
  int cyc_n = 0;
  int q [4][$];
  int last [4];
  int last_chg = -1;
  always @(posedge CLK) cyc_n++;
  initial begin
    #300000;
    $display("FAIL watchdog: time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(bit arm, bit lev, logic [2:0] dir);
    bus.ARM = arm;
    bus.LEVER = lev;
    bus.DIRECTION = dir;
  endtask
  function automatic int lane(int k);
    return int'(bus.SETPOINT[k*W +: W]);
  endfunction
  function automatic int plane(int k);
    return int'(bus.PRV_SETPOINT[k*W +: W]);
  endfunction
  function automatic int tgt(int m, int k);
    string p;
    if (m > 9) return -1;
    p = pat[m];
    return p[k] == "H" ? 10000 : p[k] == "L" ? 6000 : p[k] == "M" ? 8000 : 0;
  endfunction
  // expected ramp values for every lane, from where it stands now to the current mode's target
  task automatic seed();
    for (int k = 0; k < 4; k++) begin
      int v, t, d;
      q[k].delete();
      last[k] = lane(k);
      v = last[k];
      t = tgt(bus.MODE, k);
      while (v != t && q[k].size() < 100) begin
        d = t > v ? t - v : v - t;
        if (d > 250) d = 250;
        v = t > v ? v + d : v - d;
        q[k].push_back(v);
      end
    end
    last_chg = -1;
  endtask
  task automatic watch(int max_pops, int hold);
    int pops = 0, bad = 0, n = 0;
    while (n < 400) begin
      bit chg = 0;
      for (int k = 0; k < 4; k++)
        if (lane(k) != last[k]) begin
          chg = 1;
          if (q[k].size() == 0) chk($sformatf("lane%0d extra step", k), lane(k), last[k]);
          else begin
            chk($sformatf("lane%0d ramp", k), lane(k), q[k].pop_front());
            if (k == 0) pops++;
          end
          last[k] = lane(k);
        end
      if (chg) begin
        if (last_chg >= 0) chk("tick gap", cyc_n - last_chg, 4);
        last_chg = cyc_n;
      end
      if (hold >= 0 && int'(bus.MODE) != hold) bad++;
      if (max_pops > 0 && pops >= max_pops) break;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
      cyc();
      n++;
    end
    chk("ramp within budget", n < 400, 1);
    if (hold >= 0) chk("mode held during ramp", bad, 0);
    if (max_pops == 0) chk("busy after ramp", bus.RAMP_BUSY, 0);
  endtask
  task automatic wait_chg(string name, int budget);
    int n = 0;
    while (!bus.MODE_CHG && n < budget) begin
      cyc();
      n++;
    end
    chk({name, " mode_chg seen"}, bus.MODE_CHG, 1);
  endtask
  task automatic go(bit lev, logic [2:0] dir, int exp);
    drive(1, lev, dir);
    wait_chg("enter", 20);
    chk("enter mode", bus.MODE, exp);
    chk("enter prv_mode", bus.PRV_MODE, 0);
    seed();
    cyc();
    chk("enter mode_chg one cycle", bus.MODE_CHG, 0);
  endtask
  task automatic back(bit lev, int from);
    drive(1, lev, 3'd0);
    wait_chg("leave", 20);
    chk("leave mode", bus.MODE, 0);
    chk("leave prv_mode", bus.PRV_MODE, from);
    for (int k = 0; k < 4; k++) chk($sformatf("prv_setpoint%0d", k), plane(k), tgt(from, k));
    seed();
    cyc();
    chk("leave mode_chg one cycle", bus.MODE_CHG, 0);
    watch(0, -1);
  endtask
  task automatic idle_hold(bit lev, logic [2:0] dir, int n, output int seen);
    drive(1, lev, dir);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.MODE_CHG) seen++;
    end
  endtask
  initial begin
    int seen;
    pat = '{"MMMM", "LHHL", "HLLH", "LLHH", "HHLL", "HLHL", "LHLH", "HHHH", "LLLL", "0000"};
    tbl = '{'{1, 3'd1, 1}, '{1, 3'd2, 2}, '{1, 3'd3, 3}, '{1, 3'd4, 4},
            '{0, 3'd1, 7}, '{0, 3'd2, 8}, '{0, 3'd3, 6}, '{0, 3'd4, 5}};
    drive(1, 1, 3'd1);
    repeat (2) cyc();
    chk("reset mode", bus.MODE, 0);
    chk("reset prv_mode", bus.PRV_MODE, 0);
    chk("reset busy", bus.RAMP_BUSY, 0);
    chk("reset mode_chg", bus.MODE_CHG, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset setpoint%0d", k), lane(k), 8000);
      chk($sformatf("reset prv_setpoint%0d", k), plane(k), 8000);
    end
    @(negedge CLK) nRST = 1'b1;
    // decode table: enter each motion mode from hover, ramp out, return and ramp back
    foreach (tbl[i]) begin
      go(tbl[i].lev, tbl[i].dir, tbl[i].exp);
      watch(0, -1);
      for (int k = 0; k < 4; k++)
        chk($sformatf("mode%0d lane%0d target", tbl[i].exp, k), lane(k), tgt(tbl[i].exp, k));
      back(tbl[i].lev, tbl[i].exp);
    end
    // glitching command never settles
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, i % 2 == 0 ? 3'd1 : 3'd0);
      cyc();
      if (bus.MODE_CHG) seen++;
    end
    chk("glitch mode", bus.MODE, 0);
    chk("glitch mode_chg", seen, 0);
    go(0, 3'd4, 5);
    watch(0, -1);
    back(0, 5);
    // unused directions keep hover
    seen = 0;
    idle_hold(0, 3'd6, 8, seen);
    idle_hold(1, 3'd6, 8, seen);
    chk("dir6 mode", bus.MODE, 0);
    chk("dir6 mode_chg", seen, 0);
    // leaving UP waits for the ramp to finish
    go(0, 3'd1, 7);
    watch(4, -1);
    chk("up midpoint", lane(0), 9000);
    drive(1, 0, 3'd0);
    watch(0, 7);
    wait_chg("up to hover", 3);
    chk("up to hover mode", bus.MODE, 0);
    chk("up to hover prv_mode", bus.PRV_MODE, 7);
    for (int k = 0; k < 4; k++) chk($sformatf("up prv_setpoint%0d", k), plane(k), 10000);
    seed();
    watch(0, -1);
    // disarm mid-ramp, then rearm only once the ramp to zero is done
    go(1, 3'd1, 1);
    watch(3, -1);
    drive(0, 1, 3'd1);
    cyc();
    chk("disarm mode", bus.MODE, 9);
    chk("disarm prv_mode", bus.PRV_MODE, 1);
    chk("disarm mode_chg", bus.MODE_CHG, 1);
    seed();
    drive(1, 0, 3'd0);
    watch(0, 9);
    for (int k = 0; k < 4; k++) chk($sformatf("disarm lane%0d", k), lane(k), 0);
    wait_chg("rearm", 10);
    chk("rearm mode", bus.MODE, 0);
    chk("rearm prv_mode", bus.PRV_MODE, 9);
    for (int k = 0; k < 4; k++) chk($sformatf("rearm prv_setpoint%0d", k), plane(k), 0);
    seed();
    watch(0, -1);
    // asynchronous reset between edges mid-ramp
    go(0, 3'd1, 7);
    watch(2, -1);
    drive(1, 0, 3'd0);
    #2 nRST = 1'b0;
    #1;
    chk("async reset mode", bus.MODE, 0);
    chk("async reset prv_mode", bus.PRV_MODE, 0);
    chk("async reset busy", bus.RAMP_BUSY, 0);
    chk("async reset mode_chg", bus.MODE_CHG, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("async reset setpoint%0d", k), lane(k), 8000);
    @(negedge CLK) nRST = 1'b1;
    repeat (8) cyc();
    chk("post reset mode", bus.MODE, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mode_ramp_fsm.md
Name:
mode_ramp_fsm

Overview:
- Parametrised successor of the quadrotor flight-mode FSM. It decodes the LEVER/DIRECTION pilot command into nine flight modes plus a DISARM mode, and produces per-fan RPM setpoints.
- Setpoints change by a slew-limited ramp rather than a step change.
- Commands are debounced, and mode changes are held until the current ramp has finished.
- Feeds the per-fan PID blocks with a current setpoint (SETPOINT) and a previous-mode target (PRV_SETPOINT).

Parameters:
- RPM_W, 14: setpoint width in bits. Legal only if HOVER_RPM+DELTA_RPM < 2^RPM_W.
- HOVER_RPM, 8000: hover target RPM.
- DELTA_RPM, 2000: high target = HOVER+DELTA; low target = HOVER-DELTA.
- STEP_RPM, 250: maximum setpoint change per ramp tick.
- TICK_DIV, 1000: clocks per ramp tick. Must be ≥1.
- DEB_CYCLES, 4: consecutive clocks a command must be stable before it is accepted. Must be ≥1.

Ports:
- CLK, in, 1: clock.
- nRST, in, 1: reset, asynchronous, active-low.
- ARM, in, 1: 0 = force DISARM mode.
- LEVER, in, 1: mode group select.
- DIRECTION, in, 3: direction command.
- SETPOINT, out, 4*RPM_W: live ramped setpoints; fan k occupies bits [k*RPM_W +: RPM_W], k = 0..3 for fan1..fan4.
- PRV_SETPOINT, out, 4*RPM_W: target setpoints of PRV_MODE, same packing.
- MODE, out, 4: current mode.
- PRV_MODE, out, 4: mode before the last transition.
- RAMP_BUSY, out, 1: 1 while any SETPOINT differs from its target.
- MODE_CHG, out, 1: one-cycle pulse when MODE changes.

Behaviour:
- Mode encoding:
  - HOVER=0, FORWARD=1, BACKWARD=2, RIGHT=3, LEFT=4, CW=5, CCW=6, UP=7, DOWN=8, DISARM=9.
  - MODE must never take values 10–15.
- Reset (async) values:
  - MODE = PRV_MODE = HOVER.
  - Every SETPOINT lane = HOVER_RPM; every PRV_SETPOINT lane = HOVER_RPM.
  - RAMP_BUSY = 0, MODE_CHG = 0.
  - Tick counter = 0, debounce counter = 0.
- Debounce:
  - cmd = {LEVER, DIRECTION} is registered every clock.
  - The counter clears when cmd differs from the previous cycle and saturates at DEB_CYCLES.
  - cmd_ok = (counter == DEB_CYCLES). The accepted command is the registered cmd while cmd_ok = 1.
- Transitions (registered; evaluated every clock, in priority order):
  1. ARM == 0 and MODE != DISARM → DISARM. Immediate; ignores cmd_ok and RAMP_BUSY.
  2. DISARM → HOVER when ARM=1, cmd_ok, DIRECTION=0 and RAMP_BUSY=0.
  3. HOVER, with cmd_ok and RAMP_BUSY=0:
     - LEVER=1: DIRECTION 1/2/3/4 → FORWARD/BACKWARD/RIGHT/LEFT.
     - LEVER=0: DIRECTION 1/2/3/4 → UP/DOWN/CCW/CW.
     - DIRECTION 0 or 5–7 → stay in HOVER.
  4. Any motion mode → HOVER when cmd_ok, DIRECTION=0 and RAMP_BUSY=0. Otherwise stay. No direct motion-to-motion transitions.
- On every MODE change:
  - PRV_MODE takes the old MODE in the same edge.
  - MODE_CHG = 1 for exactly the next cycle.
- Targets per mode, as (fan1, fan2, fan3, fan4); H = high, L = low, M = HOVER_RPM:
  - FORWARD: L, H, H, L.
  - BACKWARD: H, L, L, H.
  - RIGHT: L, L, H, H.
  - LEFT: H, H, L, L.
  - CW: H, L, H, L.
  - CCW: L, H, L, H.
  - UP: all H.
  - DOWN: all L.
  - HOVER: all M.
  - DISARM: all 0.
- PRV_SETPOINT: combinational target table applied to PRV_MODE.
- Ramp:
  - The tick counter counts 0..TICK_DIV-1 and wraps. A tick occurs on the wrap cycle.
  - On a tick, each lane moves toward its target by min(STEP_RPM, |target − SETPOINT|). Arithmetic is unsigned RPM_W bits and never overshoots or underflows.
  - Lanes ramp independently.
  - Target changes mid-ramp (DISARM): the ramp continues from the current value toward the new target.
  - The tick counter is not reset by mode changes.
- RAMP_BUSY is combinational: OR over lanes of (SETPOINT ≠ target(MODE)).
- Reset asserted mid-ramp: all registers return to their reset values immediately.

Test Plan:
Bench overrides: TICK_DIV=4, DEB_CYCLES=3; all other parameters default.
1. Release reset with LEVER=1, DIR=1 held 3 clocks → MODE=1, MODE_CHG pulses one cycle, PRV_MODE=0. Lanes 1,4 ramp 8000→7750→…→6000 and lanes 2,3 ramp 8000→…→10000, one step per 4 clocks (8 ticks). RAMP_BUSY falls after the 8th tick.
2. DIR glitches 1→0→1 on alternate clocks → debounce never saturates and MODE stays HOVER. Hold DIR=4 with LEVER=0 for 3 clocks → MODE=CW.
3. In UP with the ramp at 9000, assert DIR=0 stably → MODE holds UP until SETPOINT reaches 10000, then → HOVER. PRV_SETPOINT then reads 10000 on all lanes.
4. Set ARM=0 mid-ramp in FORWARD → MODE=DISARM on the next edge. All lanes ramp to 0, with the final step smaller than 250 where needed. Then ARM=1, DIR=0 → HOVER only after RAMP_BUSY=0.
5. In HOVER, apply DIR=6 (LEVER=0 and LEVER=1) → MODE stays 0 and MODE_CHG stays 0.
6. Assert nRST low mid-ramp (asynchronous, between edges) → MODE=0, all SETPOINT lanes = 8000, RAMP_BUSY=0 immediately.
